// File: rtl/dm_pkg.sv
// Shared DMI transport types between the DTM and the debug module.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_req_fifo.sv
// Circular request FIFO of Depth entries; head is read straight out of storage.
module dmi_req_fifo
    import dm::*;
#(
    parameter int Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  dmi_req_t data_i,
    input  logic     pop_i,
    output dmi_req_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    dmi_req_t        r_mem [Depth];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_cnt;
    logic            w_push;
    logic            w_pop;

    assign full_o  = (r_cnt == CntW'(Depth));
    assign empty_o = (r_cnt == '0);
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign data_o  = r_mem[r_rptr];

    // NOTE: storage is left unreset; empty_o gates every consumer, so stale slots are never used.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

    // NOTE: registers use <= so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + PtrW'(1);
            if (w_pop)  r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + PtrW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dmi_req_buffer.sv
// DMI request queue with a single outstanding DM transaction and a response watchdog
// that turns a silent DM into an error response.
module dmi_req_buffer
    import dm::*;
#(
    parameter int Depth         = 2,
    parameter int TimeoutCycles = 1024
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  dmi_req_t  slv_req_i,
    input  logic      slv_req_valid_i,
    output logic      slv_req_ready_o,
    output dmi_resp_t slv_resp_o,
    output logic      slv_resp_valid_o,
    input  logic      slv_resp_ready_i,
    output dmi_req_t  mst_req_o,
    output logic      mst_req_valid_o,
    input  logic      mst_req_ready_i,
    input  dmi_resp_t mst_resp_i,
    input  logic      mst_resp_valid_i,
    output logic      mst_resp_ready_o,
    output logic      timeout_o
);

    typedef enum logic [2:0] {Idle, Issue, WaitResp, Drain, Respond} state_e;

    localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam dmi_resp_t ErrResp = '{data: 32'h0, resp: DTM_ERR};
    localparam dmi_resp_t NopResp = '{data: 32'h0, resp: DTM_SUCCESS};

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    dmi_resp_t       r_resp, w_resp_d;
    logic            r_timeout, w_timeout_d;
    logic            r_stale_done, w_stale_d;
    logic            r_err_taken, w_taken_d;
    logic            w_pop, w_push, w_full, w_empty, w_expire;
    logic            w_absorb, w_took;
    dmi_req_t        w_head;

    assign w_push = slv_req_valid_i && !w_full;

    dmi_req_fifo #(.Depth(Depth)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (slv_req_i),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_expire = (TimeoutCycles != 0) && (r_cnt == CntLast);
    // Drain may exit once the stale slot is closed (response or second expiry) and the error is taken.
    assign w_absorb = r_stale_done || mst_resp_valid_i || w_expire;
    assign w_took   = r_err_taken || slv_resp_ready_i;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_resp_d    = r_resp;
        w_timeout_d = 1'b0;
        w_stale_d   = r_stale_done;
        w_taken_d   = r_err_taken;
        w_pop       = 1'b0;
        case (r_state)
            Idle: begin
                if (!w_empty) begin
                    if (w_head.op == DTM_NOP) begin
                        w_pop     = 1'b1;
                        w_resp_d  = NopResp;
                        w_state_d = Respond;
                    end else begin
                        w_state_d = Issue;
                    end
                end
            end
            Issue: begin
                if (mst_req_ready_i) begin
                    w_pop     = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = WaitResp;
                end
            end
            WaitResp: begin
                w_cnt_d = r_cnt + CntW'(1);
                if (mst_resp_valid_i) begin
                    w_resp_d  = mst_resp_i;
                    w_state_d = Respond;
                end else if (w_expire) begin
                    w_resp_d    = ErrResp;
                    w_timeout_d = 1'b1;
                    w_cnt_d     = '0;
                    w_stale_d   = 1'b0;
                    w_taken_d   = 1'b0;
                    w_state_d   = Drain;
                end
            end
            Drain: begin
                if (!r_stale_done) w_cnt_d = r_cnt + CntW'(1);
                w_stale_d = w_absorb;
                w_taken_d = w_took;
                if (w_absorb && w_took) begin
                    w_stale_d = 1'b0;
                    w_taken_d = 1'b0;
                    w_state_d = Idle;
                end
            end
            Respond: begin
                if (slv_resp_ready_i) w_state_d = Idle;
            end
            default: w_state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= Idle;
            r_cnt        <= '0;
            r_resp       <= '0;
            r_timeout    <= 1'b0;
            r_stale_done <= 1'b0;
            r_err_taken  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_resp       <= w_resp_d;
            r_timeout    <= w_timeout_d;
            r_stale_done <= w_stale_d;
            r_err_taken  <= w_taken_d;
        end
    end

    assign slv_req_ready_o  = !w_full;
    assign slv_resp_o       = r_resp;
    assign slv_resp_valid_o = (r_state == Respond) || ((r_state == Drain) && !r_err_taken);
    assign mst_req_o        = w_head;
    assign mst_req_valid_o  = (r_state == Issue);
    assign mst_resp_ready_o = (r_state == WaitResp) || (r_state == Drain);
    assign timeout_o        = r_timeout;

endmodule

// File: tb/tb_dmi_req_buffer.sv
// Scenario bench for dmi_req_buffer: a behavioural DM and response sink run in the background,
// and every request is scored against the outcome its DM latency implies.
module tb_dmi_req_buffer;
    import dm::*;

    localparam int Depth = 2;
    localparam int T     = 8;

    typedef struct {
        dmi_req_t    req;
        int          d;
        logic [31:0] data;
        logic [1:0]  rc;
    } plan_t;

    logic      clk;
    logic      rst_ni;
    dmi_req_t  slv_req_i;
    logic      slv_req_valid_i;
    logic      slv_req_ready_o;
    dmi_resp_t slv_resp_o;
    logic      slv_resp_valid_o;
    logic      slv_resp_ready_i;
    dmi_req_t  mst_req_o;
    logic      mst_req_valid_o;
    logic      mst_req_ready_i;
    dmi_resp_t mst_resp_i;
    logic      mst_resp_valid_i;
    logic      mst_resp_ready_o;
    logic      timeout_o;

    dmi_req_buffer #(.Depth(Depth), .TimeoutCycles(T)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .slv_req_i        (slv_req_i),
        .slv_req_valid_i  (slv_req_valid_i),
        .slv_req_ready_o  (slv_req_ready_o),
        .slv_resp_o       (slv_resp_o),
        .slv_resp_valid_o (slv_resp_valid_o),
        .slv_resp_ready_i (slv_resp_ready_i),
        .mst_req_o        (mst_req_o),
        .mst_req_valid_o  (mst_req_valid_o),
        .mst_req_ready_i  (mst_req_ready_i),
        .mst_resp_i       (mst_resp_i),
        .mst_resp_valid_i (mst_resp_valid_i),
        .mst_resp_ready_o (mst_resp_ready_o),
        .timeout_o        (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    plan_t     plan_q[$];
    dmi_resp_t exp_q[$];
    int        n_cmp = 0;
    int        n_bad = 0;
    int        cyc = 0;
    int        dm_cnt = 0;
    int        dm_acc = 0;
    int        last_acc = -1000;
    int        exp_rv_cyc = -1;
    int        exp_to = 0;
    int        got_to = 0;
    int        dm_ready_mode = 1;
    bit        rsp_rand = 1'b0;
    bit        dm_pend_real = 1'b0;
    dmi_resp_t dm_pend;

    initial forever @(posedge clk) cyc = cyc + 1;

    // Behavioural DM: accepts requests, checks them against the planned order, replies after d cycles.
    initial begin
        plan_t    p;
        dmi_req_t prev_req;
        bit       prev_stall;
        bit       rdy;
        prev_stall       = 1'b0;
        prev_req         = '0;
        mst_req_ready_i  = 1'b0;
        mst_resp_valid_i = 1'b0;
        mst_resp_i       = '0;
        forever begin
            @(negedge clk);
            mst_resp_valid_i = 1'b0;
            if (dm_cnt > 0) begin
                dm_cnt = dm_cnt - 1;
                if (dm_cnt == 0) begin
                    mst_resp_valid_i = 1'b1;
                    mst_resp_i       = dm_pend;
                    if (dm_pend_real) exp_rv_cyc = cyc + 1;
                end
            end
            if (!rst_ni) begin
                prev_stall      = 1'b0;
                mst_req_ready_i = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_cmp++;
                    if (mst_req_valid_o !== 1'b1 || mst_req_o !== prev_req) begin
                        n_bad++;
                        $display("FAIL req_hold: valid=%b req=%h, required valid=1 req=%h",
                                 mst_req_valid_o, mst_req_o, prev_req);
                    end
                end
                case (dm_ready_mode)
                    0:       rdy = 1'b0;
                    1:       rdy = 1'b1;
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                mst_req_ready_i = rdy;
                if (mst_req_valid_o === 1'b1 && rdy) begin
                    n_cmp++;
                    if (plan_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL dm_unexpected_req: got %h, required no request", mst_req_o);
                    end else begin
                        p = plan_q.pop_front();
                        if (mst_req_o !== p.req) begin
                            n_bad++;
                            $display("FAIL dm_req_order: got %h, required %h", mst_req_o, p.req);
                        end
                        last_acc = cyc + 1;
                        dm_acc++;
                        if (p.d > 0) begin
                            dm_cnt       = p.d;
                            dm_pend.data = p.data;
                            dm_pend.resp = p.rc;
                            dm_pend_real = (p.d <= T);
                        end
                        if (p.d < 0 || p.d > T) exp_to++;
                    end
                end
                prev_stall = (mst_req_valid_o === 1'b1) && !rdy;
                prev_req   = mst_req_o;
            end
        end
    end

    // Response sink: scores every response handshake, its latency and every watchdog pulse.
    initial begin
        bit        rdy;
        dmi_resp_t e;
        slv_resp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                slv_resp_ready_i = 1'b0;
            end else begin
                if (cyc == exp_rv_cyc) begin
                    n_cmp++;
                    if (slv_resp_valid_o !== 1'b1) begin
                        n_bad++;
                        $display("FAIL resp_latency: slv_resp_valid_o=%b one cycle after DM response, required 1",
                                 slv_resp_valid_o);
                    end
                end
                if (timeout_o === 1'b1) begin
                    got_to++;
                    n_cmp++;
                    if (cyc - last_acc != T) begin
                        n_bad++;
                        $display("FAIL timeout_time: pulse %0d cycles after accept, required %0d",
                                 cyc - last_acc, T);
                    end
                end
                rdy = rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                slv_resp_ready_i = rdy;
                if (slv_resp_valid_o === 1'b1 && rdy) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL resp_unexpected: got %h, required no response", slv_resp_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (slv_resp_o !== e) begin
                            n_bad++;
                            $display("FAIL resp_data: got %h, required %h", slv_resp_o, e);
                        end
                    end
                end
            end
        end
    end

    function automatic dmi_req_t mk(input logic [6:0] a, input dtm_op_e op, input logic [31:0] d);
        dmi_req_t r;
        r.addr = a;
        r.op   = op;
        r.data = d;
        return r;
    endfunction

    // d: DM reply latency in cycles after acceptance; d < 0 means the DM never replies.
    task automatic push_req(input dmi_req_t r, input int d, input logic [31:0] data, input logic [1:0] rc);
        plan_t     p;
        dmi_resp_t e;
        int        n = 0;
        @(negedge clk);
        slv_req_i       = r;
        slv_req_valid_i = 1'b1;
        while (slv_req_ready_o !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_stuck: slv_req_ready_o=%b for 500 cycles, required 1", slv_req_ready_o);
        end else begin
            if (r.op == DTM_NOP) begin
                e.data = 32'h0;
                e.resp = DTM_SUCCESS;
            end else begin
                p.req  = r;
                p.d    = d;
                p.data = data;
                p.rc   = rc;
                plan_q.push_back(p);
                e.data = (d >= 1 && d <= T) ? data : 32'h0;
                e.resp = (d >= 1 && d <= T) ? rc   : DTM_ERR;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 slv_req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        #1;
        while (!(exp_q.size() == 0 && plan_q.size() == 0 && dm_cnt == 0 &&
                 mst_resp_ready_o === 1'b0 && slv_resp_valid_o === 1'b0 &&
                 mst_req_valid_o === 1'b0) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (n >= 3000) begin
            n_bad++;
            $display("FAIL %s_idle: %0d responses and %0d DM requests outstanding, required 0",
                     name, exp_q.size(), plan_q.size());
        end
    endtask

    task automatic wait_accept(input int base, output int a);
        int n = 0;
        while (dm_acc == base && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (dm_acc == base) begin
            n_bad++;
            $display("FAIL accept_wait: DM accepts=%0d, required %0d", dm_acc, base + 1);
        end
        a = last_acc;
    endtask

    task automatic check_reset_values(input string name);
        n_cmp += 6;
        if (slv_resp_o !== '0) begin
            n_bad++; $display("FAIL %s_slv_resp: got %h, required 0", name, slv_resp_o);
        end
        if (slv_resp_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL %s_slv_resp_valid: got %b, required 0", name, slv_resp_valid_o);
        end
        if (mst_req_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL %s_mst_req_valid: got %b, required 0", name, mst_req_valid_o);
        end
        if (slv_req_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL %s_slv_req_ready: got %b, required 1", name, slv_req_ready_o);
        end
        if (mst_resp_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL %s_mst_resp_ready: got %b, required 0", name, mst_resp_ready_o);
        end
        if (timeout_o !== 1'b0) begin
            n_bad++; $display("FAIL %s_timeout: got %b, required 0", name, timeout_o);
        end
    endtask

    task automatic apply_reset(input string name);
        @(posedge clk);
        #2;
        rst_ni          = 1'b0;
        slv_req_valid_i = 1'b0;
        plan_q.delete();
        exp_q.delete();
        dm_pend_real    = 1'b0;
        exp_rv_cyc      = -1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values(name);
        @(posedge clk);
        #2 rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_read();
        dm_ready_mode = 1;
        rsp_rand      = 1'b0;
        push_req(mk(7'h11, DTM_READ, 32'h0), 3, 32'hDEADBEEF, DTM_SUCCESS);
        wait_idle("read");
    endtask

    task automatic test_back_to_back();
        dmi_req_t w1, w2, w3;
        w1 = mk(7'h04, DTM_WRITE, 32'h1111_0001);
        w2 = mk(7'h05, DTM_WRITE, 32'h2222_0002);
        w3 = mk(7'h06, DTM_WRITE, 32'h3333_0003);
        dm_ready_mode = 0;
        push_req(w1, 2, 32'h0, DTM_SUCCESS);
        push_req(w2, 4, 32'h0, DTM_SUCCESS);
        @(negedge clk);
        #1;
        n_cmp += 2;
        if (slv_req_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL bp_full: slv_req_ready_o=%b, required 0", slv_req_ready_o);
        end
        if (mst_req_valid_o !== 1'b1 || mst_req_o !== w1) begin
            n_bad++; $display("FAIL bp_head: valid=%b req=%h, required valid=1 req=%h",
                              mst_req_valid_o, mst_req_o, w1);
        end
        fork
            push_req(w3, 1, 32'h0, DTM_BUSY);
            begin
                repeat (4) @(negedge clk);
                dm_ready_mode = 1;
            end
        join
        wait_idle("back_to_back");
    endtask

    task automatic test_timeout();
        int base, a, n;
        dm_ready_mode = 1;
        rsp_rand      = 1'b0;
        base          = dm_acc;
        push_req(mk(7'h10, DTM_READ, 32'h0), -1, 32'h0, DTM_SUCCESS);
        wait_accept(base, a);
        n = 0;
        while (cyc != a + 2 * T - 1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (mst_resp_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL drain_hold: mst_resp_ready_o=%b before second expiry, required 1",
                              mst_resp_ready_o);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (mst_resp_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL drain_exit: mst_resp_ready_o=%b after second expiry, required 0",
                              mst_resp_ready_o);
        end
        wait_idle("timeout");
    endtask

    task automatic test_late();
        int base;
        base = got_to;
        push_req(mk(7'h12, DTM_READ, 32'h0), 12, 32'hBAD0_BAD0, DTM_SUCCESS);
        push_req(mk(7'h13, DTM_READ, 32'h0), 2, 32'hA5A5_5A5A, DTM_SUCCESS);
        wait_idle("late");
        n_cmp++;
        if (got_to !== base + 1) begin
            n_bad++; $display("FAIL late_pulses: got %0d timeouts, required %0d", got_to - base, 1);
        end
    endtask

    task automatic test_race();
        int base;
        base = got_to;
        push_req(mk(7'h14, DTM_READ, 32'h0), T, 32'hCAFE_0008, DTM_SUCCESS);
        wait_idle("race");
        n_cmp++;
        if (got_to !== base) begin
            n_bad++; $display("FAIL race_pulse: got %0d timeouts, required 0", got_to - base);
        end
    endtask

    task automatic test_nop();
        int base;
        base = dm_acc;
        push_req(mk(7'h15, DTM_NOP, 32'h1234_5678), 1, 32'h0, DTM_SUCCESS);
        wait_idle("nop");
        n_cmp++;
        if (dm_acc !== base) begin
            n_bad++; $display("FAIL nop_forwarded: DM accepts=%0d, required %0d", dm_acc, base);
        end
    endtask

    task automatic test_reset_mid();
        int base, a;
        dm_ready_mode = 1;
        rsp_rand      = 1'b0;
        base          = dm_acc;
        push_req(mk(7'h16, DTM_READ, 32'h0), 6, 32'hFEED_F00D, DTM_SUCCESS);
        push_req(mk(7'h17, DTM_WRITE, 32'h0BAD_C0DE), 2, 32'h0, DTM_SUCCESS);
        wait_accept(base, a);
        repeat (3) @(negedge clk);
        apply_reset("reset_mid");
        repeat (12) @(negedge clk);
        #1;
        n_cmp++;
        if (mst_req_valid_o !== 1'b0 || slv_req_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid_empty: mst_req_valid=%b slv_req_ready=%b, required 0 and 1",
                              mst_req_valid_o, slv_req_ready_o);
        end
        push_req(mk(7'h18, DTM_READ, 32'h0), 2, 32'h0000_5EED, DTM_SUCCESS);
        wait_idle("after_reset");
    endtask

    task automatic test_random();
        dtm_op_e     op;
        int          d;
        logic [31:0] data;
        logic [1:0]  rc;
        dm_ready_mode = 2;
        rsp_rand      = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op = dtm_op_e'(2'($urandom_range(0, 2)));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: d = int'($urandom_range(1, 6));
                6:                d = T;
                7:                d = int'($urandom_range(T + 1, 2 * T - 1));
                8:                d = -1;
                default:          d = T - 1;
            endcase
            data = $urandom;
            rc   = ($urandom_range(0, 3) == 0) ? DTM_BUSY : DTM_SUCCESS;
            push_req(mk(7'($urandom_range(0, 127)), op, $urandom), d, data, rc);
            if ($urandom_range(0, 3) == 0) wait_idle("random");
        end
        wait_idle("random_end");
    endtask

    task automatic test_totals();
        n_cmp++;
        if (got_to !== exp_to) begin
            n_bad++; $display("FAIL timeout_count: got %0d pulses, required %0d", got_to, exp_to);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_ni          = 1'b0;
        slv_req_i       = '0;
        slv_req_valid_i = 1'b0;
        test_reset();
        test_read();
        test_back_to_back();
        test_timeout();
        test_late();
        test_race();
        test_nop();
        test_reset_mid();
        test_random();
        test_totals();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
